mpu_matrix_streamer: RTL and testbench



---
 rtl/mpu_matrix_streamer_if.sv | 31 +++
 rtl/mpu_matrix_streamer.sv | 107 ++++++++++
 tb/tb_mpu_matrix_streamer.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/mpu_matrix_streamer_if.sv
// Load and stream-out handshake bundle for the MPU matrix streamer.
// The slave side is the streamer itself; the master side is whoever feeds and drains it.
`timescale 1ns/1ps
interface mpu_matrix_streamer_if #(
  parameter int DIM   = 5,
  parameter int WIDTH = 8
);
  localparam int CW = $clog2(DIM);

  logic                       load_valid;
  logic                       load_ready;
  logic [DIM*DIM*WIDTH-1:0]   load_matrix;
  logic                       load_transpose;
  logic                       out_valid;
  logic                       out_ready;
  logic [WIDTH-1:0]           out_data;
  logic [CW-1:0]              out_row;
  logic [CW-1:0]              out_col;
  logic                       out_last;
  logic                       busy;

  modport slave (
    input  load_valid, load_matrix, load_transpose, out_ready,
    output load_ready, out_valid, out_data, out_row, out_col, out_last, busy
  );

  modport master (
    output load_valid, load_matrix, load_transpose, out_ready,
    input  load_ready, out_valid, out_data, out_row, out_col, out_last, busy
  );
endinterface

// File: rtl/mpu_matrix_streamer.sv
// Captures one flat DIMxDIM matrix and replays it as DIM*DIM elements,
// row-major or transposed, over a valid/ready byte stream.
`timescale 1ns/1ps
module mpu_matrix_streamer #(
  parameter int DIM   = 5,
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  mpu_matrix_streamer_if.slave  bus
);
  localparam int CW = $clog2(DIM);
  localparam logic [CW-1:0] LAST_IDX = CW'(DIM - 1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t                     state;
  logic [DIM*DIM*WIDTH-1:0]   matrix_buf;
  logic                       transpose;
  logic [CW-1:0]              row_cnt;
  logic [CW-1:0]              col_cnt;
  logic                       out_valid_q;
  logic                       out_last_q;
  logic [WIDTH-1:0]           out_data_q;
  logic                       load_ready_q;
  logic                       busy_q;

  logic [CW-1:0]              nxt_row;
  logic [CW-1:0]              nxt_col;
  logic [CW-1:0]              src_row;
  logic [CW-1:0]              src_col;
  logic [WIDTH-1:0]           nxt_elem;

  // Look ahead to the element that follows the current beat so the data register can load it.
  always_comb begin
    nxt_col = col_cnt + CW'(1);
    nxt_row = row_cnt;
    if (col_cnt == LAST_IDX) begin
      nxt_col = '0;
      nxt_row = row_cnt + CW'(1);
    end
    src_row  = transpose ? nxt_col : nxt_row;
    src_col  = transpose ? nxt_row : nxt_col;
    nxt_elem = matrix_buf[WIDTH*(int'(src_col) + DIM*int'(src_row)) +: WIDTH];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      matrix_buf   <= '0;
      transpose    <= 1'b0;
      row_cnt      <= '0;
      col_cnt      <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      out_data_q   <= '0;
      load_ready_q <= 1'b1;
      busy_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.load_valid) begin
            state        <= STREAM;
            matrix_buf   <= bus.load_matrix;
            transpose    <= bus.load_transpose;
            row_cnt      <= '0;
            col_cnt      <= '0;
            out_valid_q  <= 1'b1;
            out_last_q   <= 1'b0;
            // Element (0,0) is the same whether or not the stream is transposed.
            out_data_q   <= bus.load_matrix[WIDTH-1:0];
            load_ready_q <= 1'b0;
            busy_q       <= 1'b1;
          end
        end
        STREAM: begin
          if (bus.out_ready) begin
            if (out_last_q) begin
              state        <= IDLE;
              row_cnt      <= '0;
              col_cnt      <= '0;
              out_valid_q  <= 1'b0;
              out_last_q   <= 1'b0;
              out_data_q   <= '0;
              load_ready_q <= 1'b1;
              busy_q       <= 1'b0;
            end else begin
              row_cnt    <= nxt_row;
              col_cnt    <= nxt_col;
              out_data_q <= nxt_elem;
              out_last_q <= (nxt_row == LAST_IDX) && (nxt_col == LAST_IDX);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.load_ready = load_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_row    = row_cnt;
  assign bus.out_col    = col_cnt;
  assign bus.out_last   = out_last_q;
  assign bus.busy       = busy_q;
endmodule

// File: tb/tb_mpu_matrix_streamer.sv
// Randomized bench for mpu_matrix_streamer against a queue-based model of the
// expected element sequence per loaded matrix.
`timescale 1ns/1ps
module tb_mpu_matrix_streamer;
  localparam int DIM   = 5;
  localparam int WIDTH = 8;
  localparam int MW    = DIM*DIM*WIDTH;

  typedef struct packed {
    logic [7:0] d;
    logic [2:0] r;
    logic [2:0] c;
    logic       l;
  } beat_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mpu_matrix_streamer_if #(.DIM(DIM), .WIDTH(WIDTH)) bus ();
  mpu_matrix_streamer #(.DIM(DIM), .WIDTH(WIDTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  beat_t expQ[$];
  int    total = 0;
  int    bad = 0;
  bit    monOn = 1'b0;
  bit    mBusy = 1'b0;
  int    loadsTaken = 0;
  int    beatsSeen = 0;
  int    readyMode = 0;

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h want %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Expected stream: element k sits at (k/DIM, k%DIM) of the emitted matrix.
  function automatic void pushMatrix(input logic [MW-1:0] m, input logic t);
    logic [7:0] e [DIM][DIM];
    beat_t b;
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++)
        e[r][c] = m[8*(c + DIM*r) +: 8];
    for (int k = 0; k < DIM*DIM; k++) begin
      b.r = 3'(k / DIM);
      b.c = 3'(k % DIM);
      b.d = t ? e[k % DIM][k / DIM] : e[k / DIM][k % DIM];
      b.l = (k == DIM*DIM - 1);
      expQ.push_back(b);
    end
  endfunction

  initial begin
    int ph = 0;
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (readyMode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = (ph % 4 == 0) || (ph % 4 == 3);
        default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
      ph++;
    end
  end

  // Compare against the model, then advance it by what the coming edge will do.
  always @(negedge clk) begin
    beat_t hd;
    if (monOn) begin
      checkOutput("load_ready", 32'(bus.load_ready), 32'(!mBusy));
      checkOutput("out_valid", 32'(bus.out_valid), 32'(mBusy));
      checkOutput("busy", 32'(bus.busy), 32'(mBusy));
      if (mBusy && expQ.size() > 0) begin
        hd = expQ[0];
        checkOutput("out_data", 32'(bus.out_data), 32'(hd.d));
        checkOutput("out_row", 32'(bus.out_row), 32'(hd.r));
        checkOutput("out_col", 32'(bus.out_col), 32'(hd.c));
        checkOutput("out_last", 32'(bus.out_last), 32'(hd.l));
      end
      if (rst) begin
        mBusy = 1'b0;
        expQ.delete();
      end else if (mBusy) begin
        if (bus.out_ready && expQ.size() > 0) begin
          hd = expQ.pop_front();
          beatsSeen++;
          if (hd.l) mBusy = 1'b0;
        end
      end else if (bus.load_valid) begin
        pushMatrix(bus.load_matrix, bus.load_transpose);
        mBusy = 1'b1;
        loadsTaken++;
      end
    end
  end

  task automatic applyStimulus(input logic [MW-1:0] m, input logic t);
    int start;
    int n;
    bus.load_matrix    = m;
    bus.load_transpose = t;
    bus.load_valid     = 1'b1;
    start = loadsTaken;
    n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (loadsTaken == start && n < 200);
    #1;
    bus.load_valid = 1'b0;
    checkOutput("load_accept", 32'(loadsTaken != start), 32'd1);
  endtask

  task automatic waitIdle(input int budget);
    int n = 0;
    while (mBusy && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    checkOutput("drain_timeout", 32'(mBusy), 32'd0);
  endtask

  function automatic logic [MW-1:0] randMatrix();
    logic [MW-1:0] m;
    for (int i = 0; i < DIM*DIM; i++) m[8*i +: 8] = 8'($urandom);
    return m;
  endfunction

  task automatic checkResetState(input string tag);
    @(negedge clk);
    checkOutput({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
    checkOutput({tag, "_ready"}, 32'(bus.load_ready), 32'd1);
    checkOutput({tag, "_busy"}, 32'(bus.busy), 32'd0);
    checkOutput({tag, "_last"}, 32'(bus.out_last), 32'd0);
    checkOutput({tag, "_data"}, 32'(bus.out_data), 32'd0);
    checkOutput({tag, "_rowcol"}, 32'({bus.out_row, bus.out_col}), 32'd0);
  endtask

  initial begin
    logic [MW-1:0] m, a, b;
    int base;
    int n;
    rst = 1'b1;
    bus.load_valid = 1'b0;
    bus.load_matrix = '0;
    bus.load_transpose = 1'b0;
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++)
        m[8*(c + DIM*r) +: 8] = 8'(DIM*r + c + 1);

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    monOn = 1'b1;
    checkResetState("reset");

    readyMode = 0;
    applyStimulus(m, 1'b0);
    waitIdle(100);
    applyStimulus(m, 1'b1);
    waitIdle(100);

    readyMode = 1;
    applyStimulus(m, 1'b0);
    waitIdle(200);
    applyStimulus(m, 1'b1);
    waitIdle(200);

    // A competing load during streaming must be refused and leave the stream untouched.
    readyMode = 0;
    applyStimulus(m, 1'b0);
    bus.load_matrix = randMatrix();
    bus.load_transpose = 1'b1;
    bus.load_valid = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    bus.load_valid = 1'b0;
    waitIdle(100);

    a = randMatrix();
    b = randMatrix();
    applyStimulus(a, 1'b0);
    applyStimulus(b, 1'b1);
    waitIdle(100);

    applyStimulus(m, 1'b1);
    base = beatsSeen;
    n = 0;
    while (beatsSeen - base < 10 && n < 100) begin
      @(posedge clk);
      n++;
    end
    checkOutput("beat10_timeout", 32'(beatsSeen - base >= 10), 32'd1);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkResetState("midrst");
    applyStimulus(m, 1'b0);
    waitIdle(100);

    readyMode = 2;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(randMatrix(), 1'($urandom_range(0, 1)));
      waitIdle(400);
    end

    checkOutput("queue_empty", 32'(expQ.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
